dmem_lsu: RTL
=============

DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter XLEN, default `XLEN (32), data/address width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, pipeline presents a memory request.
REQ-005 SHALL have port req_ready, output, 1, unit accepts a request this cycle.
REQ-006 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3, RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 SHALL have port req_addr, input, XLEN, byte address.
REQ-009 SHALL have port req_wdata, input, XLEN, store data, right-aligned.
REQ-010 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, XLEN, extended load result.
REQ-012 SHALL have port resp_err, output, 1, misaligned or illegal request; qualified by resp_valid.
REQ-013 SHALL have ports dmem_we (output, 1), dmem_a (output, XLEN), dmem_wd (output, XLEN) and dmem_rd (input, XLEN). These form the word-only data-memory port. dmem_rd is combinational read data; writes commit on posedge.

Function
REQ-014 SHALL implement states IDLE, LOAD, RMW_RD, WRITE, RESP; req_ready=1 only in IDLE.
REQ-015 In IDLE with req_valid=1, SHALL latch we, funct3, addr and wdata in the same edge.
REQ-016 On acceptance, SHALL flag an error for any of: H/HU with addr[0]=1; W with addr[1:0]!=00; load funct3 in {011,110,111}; store funct3 >= 011.
REQ-017 SHALL transition from IDLE on an erroring request -> RESP with resp_err=1, issuing no dmem_we.
REQ-018 SHALL transition from IDLE on a valid request as follows: load -> LOAD; SW -> WRITE; SB/SH -> RMW_RD.
REQ-019 In LOAD, SHALL capture dmem_rd byte/halfword lane selected by addr[1:0], sign-extend (B,H) or zero-extend (BU,HU) or pass (W), then -> RESP.
REQ-020 In RMW_RD, SHALL capture dmem_rd merged with wdata[7:0] (SB) or wdata[15:0] (SH) into the addressed lane, other lanes unchanged, then -> WRITE.
REQ-021 In WRITE, SHALL assert dmem_we=1 for exactly one cycle with dmem_wd = merged word (SB/SH) or latched wdata (SW), then -> RESP.
REQ-022 dmem_a SHALL equal {latched addr[XLEN-1:2], 2'b00} in every non-IDLE state; in IDLE it SHALL be 0.
REQ-023 dmem_we SHALL be 1 only in WRITE.
REQ-024 In RESP, SHALL assert resp_valid=1 for one cycle, then -> IDLE; no back-pressure.
REQ-025 resp_rdata SHALL hold its value until the next load response; stores and errors SHALL drive resp_rdata=0.
REQ-026 Latency from accept edge T: error resp at T+1; LW/LB/LH/LBU/LHU and SW resp at T+2; SB/SH resp at T+3.
REQ-027 req_valid outside IDLE SHALL be ignored; the request is not accepted until req_ready is 1.

Reset
REQ-028 rstn=0 SHALL immediately force state IDLE and all registers to 0: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, dmem_we=0, dmem_a=0, dmem_wd=0.
REQ-029 Reset asserted mid-operation, including in WRITE, SHALL abort the access; dmem_we SHALL drop without waiting for a clock, and no response is produced.

Structure
REQ-030 Funct3 codes and state encoding SHALL live in a shared package/header alongside defines.v; XLEN SHALL come from defines.v.
REQ-031 Lane extract/extend and byte-lane merge SHALL be one combinational sub-module, lsu_lane.

Verification
REQ-032 Initialize dmem word 0x10 = 0x8877_6655; LB addr 0x13 -> resp_rdata 0xFFFF_FF88 at T+2; LBU addr 0x13 -> 0x0000_0088.
REQ-033 SH wdata 0x0000_ABCD addr 0x12 over word 0x1122_3344 -> single dmem_we pulse at T+2 with dmem_wd 0xABCD_3344; resp at T+3 with resp_err=0.
REQ-034 LW addr 0x21 -> resp_valid and resp_err=1 at T+1; dmem_we never asserted.
REQ-035 SW 0xDEAD_BEEF addr 0x40 with req_valid held high throughout -> req_ready=0 for two cycles; the second request is not accepted until IDLE.
REQ-036 Assert rstn=0 while in WRITE -> dmem_we=0 with no clock edge, no resp_valid, memory word unchanged.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// -----------------------------------------------------------------------------
// dmem_lsu_pkg
// Shared definitions for the data-memory load/store unit:
//   - `XLEN       default data/address width (used when no defines file is set)
//   - F3_*        RV32I load/store width codes
//   - lsu_state_e FSM state encoding
//   - req_illegal helper that classifies a request as misaligned or illegal
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

package dmem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } lsu_state_e;

    // Returns 1 for a misaligned access or a width code that is not legal
    // for the access direction. Unsigned widths exist only for loads.
    function automatic logic req_illegal(input logic       we,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
        logic bad;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = addr_lo[0];
            F3_W:    bad = (addr_lo != 2'b00);
            F3_BU:   bad = we;
            F3_HU:   bad = we | addr_lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// -----------------------------------------------------------------------------
// lsu_lane
// Combinational lane logic for the load/store unit.
//   rd        : word read from data memory
//   lane      : byte offset within the word (addr[1:0])
//   funct3    : width code
//   wdata     : right-aligned store data
//   load_data : addressed byte/halfword, sign- or zero-extended (word passes)
//   merged    : rd with the store byte/halfword inserted into the addressed lane
// -----------------------------------------------------------------------------
module lsu_lane
    import dmem_lsu_pkg::*;
#(
    parameter int XLEN = `XLEN
) (
    input  logic [XLEN-1:0] rd,
    input  logic [1:0]      lane,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] merged
);

    logic [4:0]      sh_s;
    logic [XLEN-1:0] shifted_s;

    assign sh_s      = {lane, 3'b000};
    assign shifted_s = rd >> sh_s;

    // Extract the addressed lane and extend it to full width.
    always_comb begin
        case (funct3)
            F3_B:    load_data = {{(XLEN-8){shifted_s[7]}}, shifted_s[7:0]};
            F3_H:    load_data = {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
            F3_BU:   load_data = {{(XLEN-8){1'b0}}, shifted_s[7:0]};
            F3_HU:   load_data = {{(XLEN-16){1'b0}}, shifted_s[15:0]};
            default: load_data = rd;
        endcase
    end

    // Insert the store byte/halfword into the addressed lane; other lanes keep rd.
    always_comb begin
        logic [XLEN-1:0] mask_v;
        logic [XLEN-1:0] ins_v;
        case (funct3)
            F3_B: begin
                mask_v = XLEN'(8'hFF) << sh_s;
                ins_v  = (wdata & XLEN'(8'hFF)) << sh_s;
            end
            F3_H: begin
                mask_v = XLEN'(16'hFFFF) << sh_s;
                ins_v  = (wdata & XLEN'(16'hFFFF)) << sh_s;
            end
            default: begin
                mask_v = {XLEN{1'b1}};
                ins_v  = wdata;
            end
        endcase
        merged = (rd & ~mask_v) | ins_v;
    end

endmodule

// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu
// Load/store unit between the pipeline and a word-only data memory.
// Sub-word stores are done as read-modify-write.
//   clk, rstn                 : clock, asynchronous active-low reset
//   req_valid/req_ready       : request handshake (ready only in IDLE)
//   req_we/funct3/addr/wdata  : request fields
//   resp_valid/rdata/err      : one-cycle response pulse with data/error
//   dmem_we/a/wd, dmem_rd     : word memory port, combinational read
// -----------------------------------------------------------------------------
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int XLEN = `XLEN
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_a,
    output logic [XLEN-1:0] dmem_wd,
    input  logic [XLEN-1:0] dmem_rd
);

    lsu_state_e      state_r, state_nxt_s;
    logic [2:0]      funct3_r;
    logic [XLEN-1:0] addr_r;
    logic [XLEN-1:0] wdata_r;
    logic [XLEN-1:0] wd_r;
    logic [XLEN-1:0] rdata_r;
    logic            err_r;

    logic            accept_s;
    logic            bad_s;
    logic [XLEN-1:0] load_data_s;
    logic [XLEN-1:0] merged_s;

    assign accept_s = (state_r == IDLE) && req_valid;
    assign bad_s    = req_illegal(req_we, req_funct3, req_addr[1:0]);

    lsu_lane #(.XLEN(XLEN)) u_lane (
        .rd        (dmem_rd),
        .lane      (addr_r[1:0]),
        .funct3    (funct3_r),
        .wdata     (wdata_r),
        .load_data (load_data_s),
        .merged    (merged_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!req_valid) begin
                    state_nxt_s = IDLE;
                end else if (bad_s) begin
                    state_nxt_s = RESP;
                end else if (!req_we) begin
                    state_nxt_s = LOAD;
                end else if (req_funct3 == F3_W) begin
                    state_nxt_s = WRITE;
                end else begin
                    state_nxt_s = RMW_RD;
                end
            end
            LOAD:    state_nxt_s = RESP;
            RMW_RD:  state_nxt_s = WRITE;
            WRITE:   state_nxt_s = RESP;
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Request latch, load capture, merge capture and response registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            funct3_r <= 3'b000;
            addr_r   <= {XLEN{1'b0}};
            wdata_r  <= {XLEN{1'b0}};
            wd_r     <= {XLEN{1'b0}};
            rdata_r  <= {XLEN{1'b0}};
            err_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                funct3_r <= req_funct3;
                addr_r   <= req_addr;
                wdata_r  <= req_wdata;
                err_r    <= bad_s;
                // Stores and errors report zero data; loads overwrite in LOAD.
                if (bad_s || req_we) begin
                    rdata_r <= {XLEN{1'b0}};
                end
                if (!bad_s && req_we && (req_funct3 == F3_W)) begin
                    wd_r <= req_wdata;
                end
            end
            if (state_r == LOAD) begin
                rdata_r <= load_data_s;
            end
            if (state_r == RMW_RD) begin
                wd_r <= merged_s;
            end
        end
    end

    // Outputs decode straight from registered state, so reset clears them
    // (including dmem_we) without waiting for a clock edge.
    assign req_ready  = (state_r == IDLE);
    assign resp_valid = (state_r == RESP);
    assign resp_err   = err_r;
    assign resp_rdata = rdata_r;
    assign dmem_we    = (state_r == WRITE);
    assign dmem_a     = (state_r == IDLE) ? {XLEN{1'b0}} : {addr_r[XLEN-1:2], 2'b00};
    assign dmem_wd    = wd_r;

endmodule
